// File: rtl/pool_window_reader.sv
// 3x3 max-pool window stage: feeds/consumes two external W-3 line buffers, emits one max per
// stride position. Define POOL_SIGNED_EN for two's-complement pixel compare (unsigned default).
module pool_window_reader #(
   parameter int W  = 220,
   parameter int H  = 220,
   parameter int S  = 2,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] lb0_din,
   input  logic [DW-1:0] lb0_dout,
   output logic [DW-1:0] lb1_din,
   input  logic [DW-1:0] lb1_dout,
   output logic [DW-1:0] data_out,
   output logic          out_valid,
   output logic          frame_done,
   output logic          frame_err
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   localparam logic [CW-1:0] ColLast = CW'(W - 1);
   localparam logic [CW-1:0] ColTwo  = CW'(2);
   localparam logic [RW-1:0] RowLast = RW'(H - 1);
   localparam logic [RW-1:0] RowTwo  = RW'(2);
   localparam logic [1:0]    PhLast  = 2'(S - 1);

   typedef enum logic {StIdle, StRun} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    cph_q, cph_d;
   logic [1:0]    rph_q, rph_d;
   logic          err_q, err_d;
   logic          win_q, win_d;
   logic          last_q, last_d;
   logic          adv;

   logic [DW-1:0] w_q [3][3];
   logic [DW-1:0] mx;
   logic [DW-1:0] data_out_q;
   logic          out_valid_q, frame_done_q;

   function automatic logic [1:0] ph_next(input logic [1:0] p);
      return (p == PhLast) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef POOL_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Phases hold (col-2)%S and (row-2)%S for the incoming pixel once col/row reach 2.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cph_d   = cph_q;
      rph_d   = rph_q;
      err_d   = err_q;
      win_d   = 1'b0;
      last_d  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StRun;
               err_d   = 1'b0;
               adv     = 1'b1;
            end
         end
         StRun: begin
            if (in_valid) begin
               adv = 1'b1;
            end else begin
               state_d = StIdle;
               err_d   = 1'b1;
               col_d   = '0;
               row_d   = '0;
               cph_d   = 2'd0;
               rph_d   = 2'd0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (adv) begin
         win_d  = (row_q >= RowTwo) && (col_q >= ColTwo) && (cph_q == 2'd0) && (rph_q == 2'd0);
         last_d = (col_q == ColLast) && (row_q == RowLast);
         if (col_q == ColLast) begin
            col_d = '0;
            cph_d = 2'd0;
            if (row_q == RowLast) begin
               row_d   = '0;
               rph_d   = 2'd0;
               state_d = StIdle;
            end else begin
               row_d = row_q + RW'(1);
               rph_d = (row_q >= RowTwo) ? ph_next(rph_q) : 2'd0;
            end
         end else begin
            col_d = col_q + CW'(1);
            cph_d = (col_q >= ColTwo) ? ph_next(cph_q) : 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         cph_q   <= 2'd0;
         rph_q   <= 2'd0;
         err_q   <= 1'b0;
         win_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cph_q   <= cph_d;
         rph_q   <= rph_d;
         err_q   <= err_d;
         win_q   <= win_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               w_q[r][c] <= '0;
            end
         end
      end else begin
         w_q[0][0] <= data_in;
         w_q[0][1] <= w_q[0][0];
         w_q[0][2] <= w_q[0][1];
         w_q[1][0] <= lb0_dout;
         w_q[1][1] <= w_q[1][0];
         w_q[1][2] <= w_q[1][1];
         w_q[2][0] <= lb1_dout;
         w_q[2][1] <= w_q[2][0];
         w_q[2][2] <= w_q[2][1];
      end
   end

   always_comb begin
      mx = w_q[0][0];
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (gt(w_q[r][c], mx)) mx = w_q[r][c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         out_valid_q  <= win_q;
         frame_done_q <= last_q;
         if (win_q) data_out_q <= mx;
      end
   end

   assign lb0_din    = w_q[0][2];
   assign lb1_din    = w_q[1][2];
   assign data_out   = data_out_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_pool_window_reader.sv
// Bench for pool_window_reader: S=2 and S=1 instances on an 8x8 map with modelled line buffers,
// a frame-image scoreboard and a table of frame scenarios plus a mid-frame reset sequence.
module tb_pool_window_reader;

   localparam int W = 8;
   localparam int H = 8;
   localparam int D = W - 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] data_in;

   logic [31:0] lb0_din2, lb0_dout2, lb1_din2, lb1_dout2, do2;
   logic [31:0] lb0_din1, lb0_dout1, lb1_din1, lb1_dout1, do1;
   logic        ov2, fd2, fe2, ov1, fd1, fe1;

   logic [31:0] lb2a [D];
   logic [31:0] lb2b [D];
   logic [31:0] lb1a [D];
   logic [31:0] lb1b [D];

   typedef struct {
      logic        vld;
      logic        done;
      logic [31:0] val;
      int          cyc;
   } exp_t;

   typedef struct {
      int          pat;
      int          drop_r;
      int          drop_c;
      int          gap;
      int          n2;
      int          n1;
      int          nd;
      logic        err;
      logic [31:0] first2;
   } vec_t;

   exp_t        q2[$];
   exp_t        q1[$];
   logic [31:0] cap2[$];
   logic [31:0] cap1[$];
   logic [31:0] img [H][W];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          oc2 = 0, oc1 = 0, dc2 = 0, dc1 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pool_window_reader #(.W(W), .H(H), .S(2), .DW(32)) u_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
      .lb0_din(lb0_din2), .lb0_dout(lb0_dout2), .lb1_din(lb1_din2), .lb1_dout(lb1_dout2),
      .data_out(do2), .out_valid(ov2), .frame_done(fd2), .frame_err(fe2)
   );

   pool_window_reader #(.W(W), .H(H), .S(1), .DW(32)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
      .lb0_din(lb0_din1), .lb0_dout(lb0_dout1), .lb1_din(lb1_din1), .lb1_dout(lb1_dout1),
      .data_out(do1), .out_valid(ov1), .frame_done(fd1), .frame_err(fe1)
   );

   // Free-running, never-reset W-3 deep line buffers.
   always @(posedge clk) begin
      lb2a[0] <= lb0_din2;
      lb2b[0] <= lb1_din2;
      lb1a[0] <= lb0_din1;
      lb1b[0] <= lb1_din1;
      for (int i = 1; i < D; i++) begin
         lb2a[i] <= lb2a[i-1];
         lb2b[i] <= lb2b[i-1];
         lb1a[i] <= lb1a[i-1];
         lb1b[i] <= lb1b[i-1];
      end
   end
   assign lb0_dout2 = lb2a[D-1];
   assign lb1_dout2 = lb2b[D-1];
   assign lb0_dout1 = lb1a[D-1];
   assign lb1_dout1 = lb1b[D-1];

   function automatic bit gtf(input logic [31:0] a, input logic [31:0] b);
`ifdef POOL_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   function automatic logic [31:0] wmax(input int r, input int c);
      logic [31:0] m;
      m = img[r][c];
      for (int i = r - 2; i <= r; i++) begin
         for (int j = c - 2; j <= c; j++) begin
            if (gtf(img[i][j], m)) m = img[i][j];
         end
      end
      return m;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon(input int s, input logic ov, input logic fd, input logic [31:0] d);
      exp_t e;
      int   n;
      if (!(ov || fd)) return;
      if (s == 2) begin
         oc2 += int'(ov);
         dc2 += int'(fd);
         if (ov) cap2.push_back(d);
         n = q2.size();
      end else begin
         oc1 += int'(ov);
         dc1 += int'(fd);
         if (ov) cap1.push_back(d);
         n = q1.size();
      end
      checks++;
      if (n == 0) begin
         errors++;
         $display("FAIL s%0d unexpected output at cycle %0d: out_valid=%0b frame_done=%0b data=%h",
                  s, cyc, ov, fd, d);
         return;
      end
      e = (s == 2) ? q2.pop_front() : q1.pop_front();
      if (ov !== e.vld || fd !== e.done || (e.vld && d !== e.val) || cyc != e.cyc) begin
         errors++;
         $display("FAIL s%0d output: got v=%0b done=%0b data=%h cyc=%0d expected v=%0b done=%0b data=%h cyc=%0d",
                  s, ov, fd, d, cyc, e.vld, e.done, e.val, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(2, ov2, fd2, do2);
         mon(1, ov1, fd1, do1);
      end
   end

   task automatic fill(input int pat);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            case (pat)
               0:       img[r][c] = 32'(r * W + c);
               1:       img[r][c] = 32'd0;
               default: img[r][c] = $urandom;
            endcase
         end
      end
      if (pat == 1) begin
         img[0][0] = 32'd5;
         img[2][2] = 32'hFFFF_FFFF;
      end
   endtask

   task automatic push_exp(input int s, input int r, input int c);
      exp_t e;
      bit   win;
      win   = (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
      e.vld  = win;
      e.done = (r == H - 1) && (c == W - 1);
      e.val  = win ? wmax(r, c) : 32'd0;
      e.cyc  = cyc + 2;
      if (win || e.done) begin
         if (s == 2) q2.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic run_frame(input int pat, input int drop_r, input int drop_c, input int gap);
      bit stop;
      stop = 1'b0;
      fill(pat);
      for (int r = 0; r < H && !stop; r++) begin
         for (int c = 0; c < W && !stop; c++) begin
            if (r == drop_r && c == drop_c) begin
               stop = 1'b1;
            end else begin
               @(posedge clk);
               #1;
               in_valid = 1'b1;
               data_in  = img[r][c];
               push_exp(2, r, c);
               push_exp(1, r, c);
            end
         end
      end
      if (gap > 0) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         data_in  = 32'd0;
         repeat (gap - 1) @(posedge clk);
      end
   endtask

   task automatic clear_obs();
      oc2 = 0; oc1 = 0; dc2 = 0; dc1 = 0;
      cap2.delete();
      cap1.delete();
   endtask

   task automatic check_rst_outputs(input string tag);
      chk({tag, " s2 out_valid"}, ov2, 0);
      chk({tag, " s2 data_out"}, do2, 0);
      chk({tag, " s2 frame_done"}, fd2, 0);
      chk({tag, " s2 frame_err"}, fe2, 0);
      chk({tag, " s1 out_valid"}, ov1, 0);
      chk({tag, " s1 data_out"}, do1, 0);
      chk({tag, " s1 frame_done"}, fd1, 0);
      chk({tag, " s1 frame_err"}, fe1, 0);
   endtask

   task automatic check_frames(input string tag, input int n2, input int n1, input int nd,
                               input logic err, input logic [31:0] first2);
      @(negedge clk);
      #1;
      chk({tag, " s2 count"}, oc2, n2);
      chk({tag, " s1 count"}, oc1, n1);
      chk({tag, " s2 frame_done count"}, dc2, nd);
      chk({tag, " s1 frame_done count"}, dc1, nd);
      chk({tag, " s2 frame_err"}, fe2, err);
      chk({tag, " s1 frame_err"}, fe1, err);
      chk({tag, " s2 pending"}, q2.size(), 0);
      chk({tag, " s1 pending"}, q1.size(), 0);
      chk({tag, " s2 first value"}, (cap2.size() > 0) ? cap2[0] : 32'hDEAD_BEEF, first2);
   endtask

   task automatic check_ramp_literal(input string tag);
      logic [31:0] exp1 [9];
      exp1 = '{32'd18, 32'd20, 32'd22, 32'd34, 32'd36, 32'd38, 32'd50, 32'd52, 32'd54};
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s s2 value %0d", tag, i), (cap2.size() > i) ? cap2[i] : 32'hDEAD_BEEF,
             exp1[i]);
      end
      chk({tag, " s1 first"}, (cap1.size() > 0) ? cap1[0] : 32'hDEAD_BEEF, 18);
      chk({tag, " s1 last"}, (cap1.size() > 0) ? cap1[cap1.size()-1] : 32'hDEAD_BEEF, 63);
   endtask

   initial begin
      vec_t        tbl [6];
      logic [31:0] sgn_first;
      int          acc_n2, acc_n1, acc_nd;
`ifdef POOL_SIGNED_EN
      sgn_first = 32'd5;
`else
      sgn_first = 32'hFFFF_FFFF;
`endif
      //        pat drop_r drop_c gap n2 n1  nd err  first2
      tbl[0] = '{0, -1, -1, 4, 9, 36, 1, 1'b0, 32'd18};
      tbl[1] = '{0,  4,  3, 5, 4, 13, 0, 1'b1, 32'd18};
      tbl[2] = '{0, -1, -1, 4, 9, 36, 1, 1'b0, 32'd18};
      tbl[3] = '{0, -1, -1, 0, 9, 36, 1, 1'b0, 32'd18};
      tbl[4] = '{0, -1, -1, 4, 9, 36, 1, 1'b0, 32'd18};
      tbl[5] = '{1, -1, -1, 4, 9, 36, 1, 1'b0, sgn_first};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_rst_outputs("reset");
      rst_n = 1'b1;

      acc_n2 = 0; acc_n1 = 0; acc_nd = 0;
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i].pat, tbl[i].drop_r, tbl[i].drop_c, tbl[i].gap);
         acc_n2 += tbl[i].n2;
         acc_n1 += tbl[i].n1;
         acc_nd += tbl[i].nd;
         if (tbl[i].gap >= 3) begin
            check_frames($sformatf("vec%0d", i), acc_n2, acc_n1, acc_nd, tbl[i].err,
                         tbl[i].first2);
            if (i == 0) check_ramp_literal("vec0");
            acc_n2 = 0; acc_n1 = 0; acc_nd = 0;
            clear_obs();
         end
      end

      // Mid-frame asynchronous reset while the S=1 instance is emitting.
      run_frame(2, 3, 5, 0);
      @(posedge clk);
      #3;
      chk("pre-reset s1 out_valid", ov1, 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = 32'd0;
      #1;
      check_rst_outputs("async reset");
      q2.delete();
      q1.delete();
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame(0, -1, -1, 4);
      check_frames("post-reset", 9, 36, 1, 1'b0, 32'd18);
      check_ramp_literal("post-reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
